ram_1r2w_lvt: RTL and testbench

Two-write-port, one-read-port 32-bit RAM for the replicated-memory family. Write capacity is multiplied the same way read capacity is multiplied elsewhere in the family. Each write port owns a private 1R1W bank. A Live Value Table (LVT) records, per address, which bank holds the most recent value, and the read port returns that bank's data. It sits wherever two producers must update a shared table in the same cycle while a single consumer reads it.

---
 rtl/ram_1r2w_lvt_pkg.sv | 11 +
 rtl/ram_1r1w_sync.sv | 36 +++
 rtl/ram_1r2w_lvt.sv | 122 ++++++++++++
 tb/tb_ram_1r2w_lvt.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_1r2w_lvt_pkg.sv
// Shared constants for the two-write, one-read LVT RAM.
package ram_1r2w_lvt_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned DEFAULT_BLOCKSIZE = 10;

    // LVT entry encodings: which bank holds the live value for an address.
    localparam logic LVT_BANK1 = 1'b0;
    localparam logic LVT_BANK2 = 1'b1;

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple 1R1W bank: one write port, one registered read-first read port, array not reset.
module ram_1r1w_sync #(
    parameter int unsigned AddrW = 11,
    parameter int unsigned DataW = 32
) (
    input  logic             clk,
    input  logic             w_enb,
    input  logic [AddrW-1:0] w_addr,
    input  logic [DataW-1:0] w_din,
    input  logic             r_enb,
    input  logic [AddrW-1:0] r_addr,
    output logic [DataW-1:0] r_dout
);

    localparam int unsigned Depth = 1 << AddrW;

    logic [DataW-1:0] mem [Depth];
    logic [DataW-1:0] r_dout_q;

    // Array write.
    always_ff @(posedge clk) begin
        if (w_enb) begin
            mem[w_addr] <= w_din;
        end
    end

    // Registered read; nonblocking update of mem makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (r_enb) begin
            r_dout_q <= mem[r_addr];
        end
    end

    assign r_dout = r_dout_q;

endmodule

// File: rtl/ram_1r2w_lvt.sv
// Two-write, one-read RAM: one private bank per write port, a Live Value Table picks the
// bank holding the newest value for each address.
module ram_1r2w_lvt
    import ram_1r2w_lvt_pkg::*;
#(
    parameter int unsigned BLOCKSIZE = DEFAULT_BLOCKSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BLOCKSIZE:0]  w_addr_1,
    input  logic [DATA_W-1:0]   w_din_1,
    input  logic                w_enb_1,
    input  logic [BLOCKSIZE:0]  w_addr_2,
    input  logic [DATA_W-1:0]   w_din_2,
    input  logic                w_enb_2,
    input  logic [BLOCKSIZE:0]  r_addr_1,
    input  logic                r_enb_1,
    output logic [DATA_W-1:0]   r_dout_1,
    output logic                r_valid_1,
    output logic                w_collide
);

    localparam int unsigned AddrW = BLOCKSIZE + 1;
    localparam int unsigned Depth = 1 << AddrW;

    logic              wr_en_1;
    logic              wr_en_2;
    logic [Depth-1:0]  lvt_q;
    logic              lvt_sel_q;
    logic              rd_pend_q;
    logic [DATA_W-1:0] bank1_dout;
    logic [DATA_W-1:0] bank2_dout;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] r_dout_q;
    logic              r_valid_q;
    logic              w_collide_q;

    // Writes presented during reset are dropped so the cleared LVT stays coherent.
    assign wr_en_1 = w_enb_1 & ~rst;
    assign wr_en_2 = w_enb_2 & ~rst;

    ram_1r1w_sync #(
        .AddrW(AddrW),
        .DataW(DATA_W)
    ) u_bank1 (
        .clk   (clk),
        .w_enb (wr_en_1),
        .w_addr(w_addr_1),
        .w_din (w_din_1),
        .r_enb (r_enb_1),
        .r_addr(r_addr_1),
        .r_dout(bank1_dout)
    );

    ram_1r1w_sync #(
        .AddrW(AddrW),
        .DataW(DATA_W)
    ) u_bank2 (
        .clk   (clk),
        .w_enb (wr_en_2),
        .w_addr(w_addr_2),
        .w_din (w_din_2),
        .r_enb (r_enb_1),
        .r_addr(r_addr_1),
        .r_dout(bank2_dout)
    );

    // LVT update; port 2 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvt_q <= '0;
        end else begin
            if (w_enb_1) begin
                lvt_q[w_addr_1] <= LVT_BANK1;
            end
            if (w_enb_2) begin
                lvt_q[w_addr_2] <= LVT_BANK2;
            end
        end
    end

    // Read stage 1: LVT lookup alongside the bank reads, using pre-edge state for both.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvt_sel_q <= LVT_BANK1;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= r_enb_1;
            if (r_enb_1) begin
                lvt_sel_q <= lvt_q[r_addr_1];
            end
        end
    end

    // Select the live bank's word.
    always_comb begin
        rd_data = bank1_dout;
        if (lvt_sel_q == LVT_BANK2) begin
            rd_data = bank2_dout;
        end
    end

    // Read stage 2 output registers and the collision flag; reset kills any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_q    <= '0;
            r_valid_q   <= 1'b0;
            w_collide_q <= 1'b0;
        end else begin
            r_valid_q   <= rd_pend_q;
            w_collide_q <= w_enb_1 & w_enb_2 & (w_addr_1 == w_addr_2);
            if (rd_pend_q) begin
                r_dout_q <= rd_data;
            end
        end
    end

    assign r_dout_1  = r_dout_q;
    assign r_valid_1 = r_valid_q;
    assign w_collide = w_collide_q;

endmodule

// File: tb/tb_ram_1r2w_lvt.sv
// Directed bench for ram_1r2w_lvt: reset, independent ports, ownership, collision,
// read-during-write and reset mid-stream.
module tb_ram_1r2w_lvt;

    localparam int unsigned AW = 11;

    logic          clk;
    logic          rst;
    logic [AW-1:0] w_addr_1;
    logic [31:0]   w_din_1;
    logic          w_enb_1;
    logic [AW-1:0] w_addr_2;
    logic [31:0]   w_din_2;
    logic          w_enb_2;
    logic [AW-1:0] r_addr_1;
    logic          r_enb_1;
    logic [31:0]   r_dout_1;
    logic          r_valid_1;
    logic          w_collide;

    int checks;
    int failures;

    ram_1r2w_lvt #(
        .BLOCKSIZE(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_addr_1 (w_addr_1),
        .w_din_1  (w_din_1),
        .w_enb_1  (w_enb_1),
        .w_addr_2 (w_addr_2),
        .w_din_2  (w_din_2),
        .w_enb_2  (w_enb_2),
        .r_addr_1 (r_addr_1),
        .r_enb_1  (r_enb_1),
        .r_dout_1 (r_dout_1),
        .r_valid_1(r_valid_1),
        .w_collide(w_collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        w_enb_1 = 1'b0;
        w_enb_2 = 1'b0;
        r_enb_1 = 1'b0;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [31:0] d);
        w_addr_1 = a;
        w_din_1  = d;
        w_enb_1  = 1'b1;
    endtask

    task automatic wr2(input logic [AW-1:0] a, input logic [31:0] d);
        w_addr_2 = a;
        w_din_2  = d;
        w_enb_2  = 1'b1;
    endtask

    // Issue one read and check the two-edge pipeline: no valid after the first edge,
    // valid with data after the second.
    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        r_addr_1 = a;
        r_enb_1  = 1'b1;
        tick();
        r_enb_1 = 1'b0;
        chk({tag, "_v0"}, {31'd0, r_valid_1}, 32'd0);
        tick();
        chk({tag, "_v1"}, {31'd0, r_valid_1}, 32'd1);
        chk({tag, "_d"}, r_dout_1, exp);
    endtask

    initial begin
        logic [31:0] rnd;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        w_addr_1 = '0;
        w_addr_2 = '0;
        r_addr_1 = '0;
        w_din_1  = '0;
        w_din_2  = '0;
        idle();

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            rnd = $urandom; w_addr_1 = rnd[AW-1:0]; w_enb_1 = rnd[20];
            rnd = $urandom; w_addr_2 = rnd[AW-1:0]; w_enb_2 = rnd[20];
            rnd = $urandom; r_addr_1 = rnd[AW-1:0]; r_enb_1 = rnd[20];
            w_din_1 = $urandom;
            w_din_2 = $urandom;
            tick();
            chk("rst_valid", {31'd0, r_valid_1}, 32'd0);
            chk("rst_dout", r_dout_1, 32'd0);
            chk("rst_coll", {31'd0, w_collide}, 32'd0);
        end
        rst = 1'b0;
        idle();
        tick();
        chk("post_rst_valid", {31'd0, r_valid_1}, 32'd0);

        wr1(11'd5, 32'h11);
        tick();
        idle();
        do_read("rd5", 11'd5, 32'h11);
        tick();
        chk("hold_valid", {31'd0, r_valid_1}, 32'd0);
        chk("hold_dout", r_dout_1, 32'h11);

        // Independent ports, then back-to-back reads.
        wr1(11'd3, 32'hAAAA_0001);
        wr2(11'd4, 32'hBBBB_0002);
        tick();
        idle();
        chk("nocoll", {31'd0, w_collide}, 32'd0);
        r_addr_1 = 11'd3;
        r_enb_1  = 1'b1;
        tick();
        chk("b2b_v0", {31'd0, r_valid_1}, 32'd0);
        r_addr_1 = 11'd4;
        tick();
        r_enb_1 = 1'b0;
        chk("b2b_v1", {31'd0, r_valid_1}, 32'd1);
        chk("b2b_d3", r_dout_1, 32'hAAAA_0001);
        tick();
        chk("b2b_v2", {31'd0, r_valid_1}, 32'd1);
        chk("b2b_d4", r_dout_1, 32'hBBBB_0002);
        tick();
        chk("b2b_v3", {31'd0, r_valid_1}, 32'd0);

        // Ownership transfer at address 7.
        wr2(11'd7, 32'h22);
        tick();
        idle();
        wr1(11'd7, 32'h33);
        tick();
        idle();
        do_read("own1", 11'd7, 32'h33);
        wr2(11'd7, 32'h44);
        tick();
        idle();
        do_read("own2", 11'd7, 32'h44);

        // Same-address collision at 9: port 2 wins.
        wr1(11'd9, 32'h1);
        wr2(11'd9, 32'h2);
        tick();
        idle();
        chk("coll_on", {31'd0, w_collide}, 32'd1);
        tick();
        chk("coll_off", {31'd0, w_collide}, 32'd0);
        do_read("coll_rd", 11'd9, 32'h2);

        // Read-during-write at 12 returns the old value; next read sees the new one.
        wr1(11'd12, 32'h5);
        tick();
        idle();
        wr1(11'd12, 32'h6);
        r_addr_1 = 11'd12;
        r_enb_1  = 1'b1;
        tick();
        idle();
        r_enb_1 = 1'b1;
        tick();
        r_enb_1 = 1'b0;
        chk("rdw_v_old", {31'd0, r_valid_1}, 32'd1);
        chk("rdw_old", r_dout_1, 32'h5);
        tick();
        chk("rdw_v_new", {31'd0, r_valid_1}, 32'd1);
        chk("rdw_new", r_dout_1, 32'h6);

        // Hand address 3 to port 2, then reset with a read in flight.
        wr2(11'd3, 32'hCCCC_0003);
        tick();
        idle();
        do_read("own3", 11'd3, 32'hCCCC_0003);
        r_addr_1 = 11'd3;
        r_enb_1  = 1'b1;
        tick();
        r_enb_1 = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, r_valid_1}, 32'd0);
        chk("mid_rst_dout", r_dout_1, 32'd0);
        tick();
        chk("mid_rst_valid2", {31'd0, r_valid_1}, 32'd0);
        do_read("lvt_clr3", 11'd3, 32'hAAAA_0001);
        do_read("keep5", 11'd5, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
